// File: rtl/sig_pkg.sv
// Shared definitions for the pattern/signature engine.
//   state_e     : run-control FSM states
//   LFSR_TAP_*  : feedback taps of the x^33+x^20+1 Fibonacci LFSR
//   MISR_POLY   : CRC-32 polynomial used by the signature register
//   *_W_DEF     : widths of the hidden-case netlists (33 in, 25 out)
package sig_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int LFSR_TAP_HI = 32;
  localparam int LFSR_TAP_LO = 19;

  localparam logic [31:0] MISR_POLY = 32'h04C11DB7;

  localparam int IN_W_DEF  = 33;
  localparam int OUT_W_DEF = 25;

endpackage

// File: rtl/misr32.sv
// Multiple-input signature register.
//   clk, rst : clock, synchronous active-high reset (clears the signature)
//   clr_i    : synchronous clear, wins over en_i
//   en_i     : absorb data_i this cycle
//   data_i   : response word, zero-extended to SIG_W
//   sig_o    : current signature
module misr32
  import sig_pkg::*;
#(
  parameter int OUT_W = OUT_W_DEF,
  parameter int SIG_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [OUT_W-1:0] data_i,
  output logic [SIG_W-1:0] sig_o
);

  logic [SIG_W-1:0] sig_q;
  logic [SIG_W-1:0] sig_d;

  always_comb begin
    sig_d = sig_q;
    if (clr_i) begin
      sig_d = '0;
    end else if (en_i) begin
      // Shift left, fold the MSB back through the polynomial, then mix in data.
      sig_d = {sig_q[SIG_W-2:0], 1'b0}
            ^ (sig_q[SIG_W-1] ? SIG_W'(MISR_POLY) : '0)
            ^ SIG_W'(data_i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sig_q <= '0;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig_o = sig_q;

endmodule

// File: rtl/pattern_sig_engine.sv
// Stimulus/response stage around a combinational netlist under test.
// An LFSR drives pat_o; the netlist answer on resp_i is registered and
// compacted into a MISR signature over num_pat_i patterns.
//   clk, rst     : clock, synchronous active-high reset
//   start_i      : begin a run (only honoured in IDLE or DONE)
//   num_pat_i    : pattern count, sampled when start is accepted
//   hold_i       : stall pattern issue while in RUN
//   abort_i      : return to IDLE from any state (highest priority)
//   pat_o        : pattern driven to the netlist
//   pat_vld_o    : pat_o is a counted pattern this cycle
//   resp_i       : netlist response, combinational from pat_o
//   busy_o       : RUN or DRAIN
//   done_o       : signature is final
//   sig_o        : MISR value
//   cnt_o        : patterns issued so far
//   dbg_state_o  : FSM state for observation
//
// Handshake: a pattern counts exactly in the cycles where pat_vld_o=1; its
// response is captured at the closing edge and absorbed one edge later.
module pattern_sig_engine
  import sig_pkg::*;
#(
  parameter int              IN_W  = IN_W_DEF,
  parameter int              OUT_W = OUT_W_DEF,
  parameter int              SIG_W = 32,
  parameter int              CNT_W = 16,
  parameter logic [IN_W-1:0] SEED  = 33'h1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [CNT_W-1:0] num_pat_i,
  input  logic             hold_i,
  input  logic             abort_i,
  output logic [IN_W-1:0]  pat_o,
  output logic             pat_vld_o,
  input  logic [OUT_W-1:0] resp_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [SIG_W-1:0] sig_o,
  output logic [CNT_W-1:0] cnt_o,
  output state_e           dbg_state_o
);

  // An all-zero LFSR would lock up, so a zero seed becomes 1.
  localparam logic [IN_W-1:0] SEED_FIX =
    (SEED == '0) ? {{(IN_W-1){1'b0}}, 1'b1} : SEED;

  state_e           state_q,    state_d;
  logic [IN_W-1:0]  lfsr_q,     lfsr_d;
  logic [CNT_W-1:0] cnt_q,      cnt_d;
  logic [CNT_W-1:0] target_q,   target_d;
  logic [OUT_W-1:0] resp_q,     resp_d;
  logic             resp_vld_q, resp_vld_d;

  logic             pat_vld;
  logic             misr_clr;
  logic             misr_en;
  logic [CNT_W-1:0] cnt_inc;

  assign cnt_inc = cnt_q + CNT_W'(1);

  always_comb begin
    state_d    = state_q;
    lfsr_d     = lfsr_q;
    cnt_d      = cnt_q;
    target_d   = target_q;
    resp_d     = resp_q;
    resp_vld_d = 1'b0;
    pat_vld    = 1'b0;
    misr_clr   = 1'b0;
    misr_en    = 1'b0;

    if (abort_i) begin
      // Signature and count are frozen as they stand.
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start_i) begin
            lfsr_d   = SEED_FIX;
            cnt_d    = '0;
            target_d = num_pat_i;
            misr_clr = 1'b1;
            state_d  = (num_pat_i == '0) ? ST_DONE : ST_RUN;
          end
        end
        ST_RUN: begin
          // The previous cycle's response is absorbed even while stalled.
          misr_en = resp_vld_q;
          if (!hold_i) begin
            pat_vld    = 1'b1;
            resp_d     = resp_i;
            resp_vld_d = 1'b1;
            lfsr_d     = {lfsr_q[IN_W-2:0], lfsr_q[LFSR_TAP_HI] ^ lfsr_q[LFSR_TAP_LO]};
            cnt_d      = cnt_inc;
            if (cnt_inc == target_q) begin
              state_d = ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          misr_en = resp_vld_q;
          state_d = ST_DONE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      lfsr_q     <= SEED_FIX;
      cnt_q      <= '0;
      target_q   <= '0;
      resp_q     <= '0;
      resp_vld_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_d;
      cnt_q      <= cnt_d;
      target_q   <= target_d;
      resp_q     <= resp_d;
      resp_vld_q <= resp_vld_d;
    end
  end

  misr32 #(
    .OUT_W (OUT_W),
    .SIG_W (SIG_W)
  ) u_misr (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (misr_clr),
    .en_i   (misr_en),
    .data_i (resp_q),
    .sig_o  (sig_o)
  );

  assign pat_o       = lfsr_q;
  assign pat_vld_o   = pat_vld;
  assign busy_o      = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign done_o      = (state_q == ST_DONE);
  assign cnt_o       = cnt_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_pattern_sig_engine.sv
// Bench for pattern_sig_engine: directed runs, expected patterns and
// end-of-run signature/count/latency pushed to queues by the driver and
// popped by a monitor whenever the DUT shows a pattern or finishes.
module tb_pattern_sig_engine;
  import sig_pkg::*;

  localparam int IN_W  = 33;
  localparam int OUT_W = 25;
  localparam int SIG_W = 32;
  localparam int CNT_W = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic             start, hold, abort_r;
  logic [CNT_W-1:0] num_pat;
  logic [IN_W-1:0]  pat;
  logic             pat_vld, busy, done;
  logic [OUT_W-1:0] resp;
  logic [SIG_W-1:0] sig;
  logic [CNT_W-1:0] cnt;
  state_e           dbg_state;
  int               resp_mode;

  logic             start0;
  logic [CNT_W-1:0] num_pat0;
  logic [IN_W-1:0]  pat0;
  logic             pat_vld0, busy0, done0;
  logic [SIG_W-1:0] sig0;
  logic [CNT_W-1:0] cnt0;
  state_e           dbg_state0;

  // Stand-in for the netlist: mode 0 ties low, 1 ties to 1, 2 mixes the pattern.
  function automatic logic [OUT_W-1:0] resp_model(input logic [IN_W-1:0] p, input int mode);
    case (mode)
      0:       resp_model = '0;
      1:       resp_model = 25'h1;
      default: resp_model = p[24:0] ^ {p[32:25], p[32:16]};
    endcase
  endfunction

  always_comb resp = resp_model(pat, resp_mode);

  pattern_sig_engine dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start),
    .num_pat_i   (num_pat),
    .hold_i      (hold),
    .abort_i     (abort_r),
    .pat_o       (pat),
    .pat_vld_o   (pat_vld),
    .resp_i      (resp),
    .busy_o      (busy),
    .done_o      (done),
    .sig_o       (sig),
    .cnt_o       (cnt),
    .dbg_state_o (dbg_state)
  );

  pattern_sig_engine #(.SEED(33'h0)) dut0 (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start0),
    .num_pat_i   (num_pat0),
    .hold_i      (1'b0),
    .abort_i     (1'b0),
    .pat_o       (pat0),
    .pat_vld_o   (pat_vld0),
    .resp_i      (25'h0),
    .busy_o      (busy0),
    .done_o      (done0),
    .sig_o       (sig0),
    .cnt_o       (cnt0),
    .dbg_state_o (dbg_state0)
  );

  // ---------------- reference model ----------------
  function automatic logic [IN_W-1:0] lfsr_next(input logic [IN_W-1:0] x);
    lfsr_next = {x[31:0], x[32] ^ x[19]};
  endfunction

  function automatic logic [SIG_W-1:0] misr_next(input logic [SIG_W-1:0] s, input logic [OUT_W-1:0] r);
    misr_next = {s[30:0], 1'b0} ^ (s[31] ? 32'h04C11DB7 : 32'h0) ^ {7'h0, r};
  endfunction

  // ---------------- scoreboard ----------------
  logic [IN_W-1:0]  exp_pat_q[$];
  logic [IN_W-1:0]  exp_pat0_q[$];
  logic [SIG_W-1:0] exp_sig_q[$];
  logic [CNT_W-1:0] exp_cnt_q[$];
  int               exp_lat_q[$];

  int checks = 0;
  int errors = 0;
  int start_cyc = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL %s: DUT output with nothing expected (cycle %0d)", name, cyc);
  endtask

  logic done_prev = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      if (pat_vld) begin
        if (exp_pat_q.size() == 0) unexpected("pat");
        else check("pat", 64'(pat), 64'(exp_pat_q.pop_front()));
      end
      if (pat_vld0) begin
        if (exp_pat0_q.size() == 0) unexpected("pat_seed0");
        else check("pat_seed0", 64'(pat0), 64'(exp_pat0_q.pop_front()));
      end
      if (done && !done_prev) begin
        if (exp_sig_q.size() == 0) unexpected("done");
        else begin
          check("sig", 64'(sig), 64'(exp_sig_q.pop_front()));
          check("cnt", 64'(cnt), 64'(exp_cnt_q.pop_front()));
          check("done_latency", 64'(cyc + 1 - start_cyc), 64'(exp_lat_q.pop_front()));
        end
      end
    end
    done_prev = done;
  end

  // ---------------- driver tasks ----------------
  task automatic push_pats(input int n);
    logic [IN_W-1:0] p;
    p = 33'h1;
    for (int i = 0; i < n; i++) begin
      exp_pat_q.push_back(p);
      p = lfsr_next(p);
    end
  endtask

  // Returns #1 after the accepting edge t, i.e. early in cycle t+1.
  task automatic start_run(input int n, input bit expect_done, input int lat,
                           input logic [SIG_W-1:0] s, input int c);
    if (expect_done) begin
      exp_sig_q.push_back(s);
      exp_cnt_q.push_back(CNT_W'(c));
      exp_lat_q.push_back(lat);
    end
    @(posedge clk); #1;
    num_pat = CNT_W'(n);
    start   = 1'b1;
    @(posedge clk); #1;
    start_cyc = cyc;
    start     = 1'b0;
  endtask

  task automatic wait_drained(input string name, input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      @(posedge clk);
      if (exp_pat_q.size() == 0 && exp_pat0_q.size() == 0 && exp_sig_q.size() == 0) break;
    end
    if (i == budget) begin
      checks++;
      errors++;
      $display("FAIL %s: timeout, %0d patterns and %0d results still expected",
               name, exp_pat_q.size(), exp_sig_q.size());
      exp_pat_q.delete(); exp_pat0_q.delete();
      exp_sig_q.delete(); exp_cnt_q.delete(); exp_lat_q.delete();
    end
    @(posedge clk); #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [IN_W-1:0]  p;
    logic [SIG_W-1:0] s;

    rst = 1'b1; start = 1'b0; hold = 1'b0; abort_r = 1'b0; num_pat = '0;
    start0 = 1'b0; num_pat0 = '0; resp_mode = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk); #1;
    check("rst_pat_vld", 64'(pat_vld), 64'(0));
    check("rst_busy",    64'(busy),    64'(0));
    check("rst_done",    64'(done),    64'(0));
    check("rst_sig",     64'(sig),     64'(0));
    check("rst_cnt",     64'(cnt),     64'(0));
    check("rst_pat",     64'(pat),     64'(33'h1));
    check("rst_state",   64'(dbg_state), 64'(ST_IDLE));
    check("rst_pat_seed0", 64'(pat0),  64'(33'h1));

    // N=1, response tied low; zero seed on the second instance in parallel
    resp_mode = 0;
    push_pats(1);
    exp_pat0_q.push_back(33'h1);
    num_pat0 = 16'd1;
    start0   = 1'b1;
    start_run(1, 1'b1, 3, 32'h0, 1);
    start0   = 1'b0;
    wait_drained("n1", 50);

    // N=2, response tied to 1: sig = ((0<<1)^1 <<1)^1 = 3
    resp_mode = 1;
    push_pats(2);
    start_run(2, 1'b1, 4, 32'h3, 2);
    wait_drained("n2", 50);

    // N=4 with a two-cycle hold after pattern 2: sig 1,3,7,F; done at t+8
    push_pats(4);
    start_run(4, 1'b1, 8, 32'hF, 4);
    @(posedge clk); #1;            // cycle t+2
    @(posedge clk); #1 hold = 1'b1; // cycle t+3
    @(negedge clk); #1 check("hold_vld_a", 64'(pat_vld), 64'(0));
    @(posedge clk); #1;            // cycle t+4
    @(negedge clk); #1 check("hold_vld_b", 64'(pat_vld), 64'(0));
    @(posedge clk); #1 hold = 1'b0; // cycle t+5
    wait_drained("hold", 50);

    // Abort during cycle t+3 of an N=10 run: only patterns 1,2 count
    push_pats(2);
    start_run(10, 1'b0, 0, 32'h0, 0);
    @(posedge clk); #1;               // cycle t+2
    @(posedge clk); #1 abort_r = 1'b1; // cycle t+3
    @(negedge clk); #1 check("abort_vld", 64'(pat_vld), 64'(0));
    @(posedge clk); #1 abort_r = 1'b0; // cycle t+4
    @(negedge clk); #1;
    check("abort_state", 64'(dbg_state), 64'(ST_IDLE));
    check("abort_done",  64'(done),      64'(0));
    check("abort_busy",  64'(busy),      64'(0));
    check("abort_cnt",   64'(cnt),       64'(2));

    // Fresh N=2 run after abort matches the standalone N=2 signature
    push_pats(2);
    start_run(2, 1'b1, 4, 32'h3, 2);
    wait_drained("after_abort", 50);

    // Abort from DONE clears done_o
    @(posedge clk); #1 abort_r = 1'b1;
    @(posedge clk); #1 abort_r = 1'b0;
    @(negedge clk); #1;
    check("abort_done_from_done", 64'(done), 64'(0));
    check("abort_sig_kept",       64'(sig),  64'(32'h3));

    // N=0: done in cycle t+1 with sig 0 and count 0
    start_run(0, 1'b1, 1, 32'h0, 0);
    wait_drained("n0", 50);

    // Long run with a mixing response; stray start mid-run must be ignored
    resp_mode = 2;
    p = 33'h1;
    s = '0;
    for (int i = 0; i < 1000; i++) begin
      exp_pat_q.push_back(p);
      s = misr_next(s, resp_model(p, 2));
      p = lfsr_next(p);
    end
    start_run(1000, 1'b1, 1002, s, 1000);
    repeat (400) @(posedge clk);
    #1 start = 1'b1; num_pat = 16'd3;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk); #1 check("midrun_busy", 64'(busy), 64'(1));
    wait_drained("golden", 1500);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
